// File: rtl/tdc_channel_ctrl.sv
// Per-channel TDC sequencer: source select, arm/dead-time control, tap sampling,
// thermometer-to-fine encoding and timestamp output with dropped-hit accounting.
module tdc_channel_ctrl #(
  parameter int NTAPS       = 32,
  parameter int COARSE_W    = 16,
  parameter int FINE_W      = 6,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic                       cal_mode,
  input  logic                       hit_in,
  input  logic                       cal_pulse,
  output logic                       dl_in,
  input  logic [NTAPS-1:0]           taps,
  output logic [COARSE_W+FINE_W:0]   ts_data,
  output logic                       ts_valid,
  input  logic                       ts_ready,
  output logic [7:0]                 lost_cnt,
  output logic                       busy
);

  localparam int DCNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, DEAD} state_t;

  state_t              state_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic                cal_sel_q;
  logic [COARSE_W-1:0] coarse_q;
  logic [COARSE_W-1:0] coarse_smp_q;
  logic [NTAPS-1:0]    taps_q;
  logic                tap0_prev_q;

  logic                hit_edge;
  logic [FINE_W-1:0]   fine_d;
  logic                sat_d;
  logic                found;

  // The delay-line input must stay free of flops so the hit timing is preserved.
  assign dl_in    = (state_q == ARMED) ? (cal_sel_q ? cal_pulse : hit_in) : 1'b0;
  assign busy     = (state_q != IDLE);
  assign hit_edge = taps_q[0] && !tap0_prev_q && (state_q == ARMED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coarse_q     <= '0;
      coarse_smp_q <= '0;
      taps_q       <= '0;
      tap0_prev_q  <= 1'b0;
    end else begin
      coarse_q     <= coarse_q + 1'b1;
      coarse_smp_q <= coarse_q;
      taps_q       <= taps;
      tap0_prev_q  <= taps_q[0];
    end
  end

  // First zero above bit 0 marks the end of the thermometer; later bubbles are ignored.
  always_comb begin
    fine_d = FINE_W'(NTAPS);
    found  = 1'b0;
    for (int i = 0; i < NTAPS; i++) begin
      if (!found && !taps_q[i]) begin
        fine_d = FINE_W'(i);
        found  = 1'b1;
      end
    end
    sat_d = !found;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      cal_sel_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_q   <= ARMED;
            cal_sel_q <= cal_mode;
          end
        end
        ARMED: begin
          if (hit_edge) begin
            state_q <= DEAD;
            dcnt_q  <= DCNT_W'(DEAD_CYCLES - 1);
          end else if (!arm) begin
            state_q <= IDLE;
          end
        end
        DEAD: begin
          if (dcnt_q == '0) begin
            state_q <= arm ? ARMED : IDLE;
          end else begin
            dcnt_q <= dcnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A slot frees up in the same cycle the consumer takes the old timestamp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_valid <= 1'b0;
      ts_data  <= '0;
      lost_cnt <= '0;
    end else if (hit_edge) begin
      if (!ts_valid || ts_ready) begin
        ts_data  <= {sat_d, coarse_smp_q, fine_d};
        ts_valid <= 1'b1;
      end else if (lost_cnt != 8'hFF) begin
        lost_cnt <= lost_cnt + 1'b1;
      end
    end else if (ts_valid && ts_ready) begin
      ts_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdc_channel_ctrl.sv
// Directed self-checking bench for tdc_channel_ctrl.
module tb_tdc_channel_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        cal_mode = 1'b0;
  logic        hit_in = 1'b0;
  logic        cal_pulse = 1'b0;
  logic        dl_in;
  logic [31:0] taps = '0;
  logic [22:0] ts_data;
  logic        ts_valid;
  logic        ts_ready = 1'b0;
  logic [7:0]  lost_cnt;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] exp_c;
  logic [15:0] exp_c2;
  logic [22:0] held;

  tdc_channel_ctrl #(.NTAPS(32), .COARSE_W(16), .FINE_W(6), .DEAD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .cal_mode(cal_mode), .hit_in(hit_in),
    .cal_pulse(cal_pulse), .dl_in(dl_in), .taps(taps), .ts_data(ts_data),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .lost_cnt(lost_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference coarse count: clock edges since the last reset edge.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  // Edge lands in taps_q at edge N; timestamp is visible after edge N+1.
  task send_hit(input logic [31:0] pat, input logic rdy, output logic [15:0] coarse_exp);
    taps = pat;
    tick();
    coarse_exp = 16'(cyc - 1);
    taps = '0;
    ts_ready = rdy;
    tick();
    ts_ready = 1'b0;
  endtask

  task release_and_rearm;
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
    repeat (3) tick();
  endtask

  task test_reset;
    hit_in = 1'b1;
    cal_pulse = 1'b1;
    tick();
    tick();
    checks++; if (ts_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", ts_valid); end
    checks++; if (ts_data !== 23'h0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", ts_data); end
    checks++; if (lost_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_lost: got %0d expected 0", lost_cnt); end
    checks++; if (dl_in !== 1'b0) begin failures++; $display("[TB] FAIL reset_dl_in: got %b expected 0", dl_in); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    hit_in = 1'b0;
    cal_pulse = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task test_basic;
    arm = 1'b1;
    cal_mode = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_armed_busy: got %b expected 1", busy); end
    hit_in = 1'b1; #1;
    checks++; if (dl_in !== 1'b1) begin failures++; $display("[TB] FAIL basic_dl_hit_hi: got %b expected 1", dl_in); end
    hit_in = 1'b0; #1;
    checks++; if (dl_in !== 1'b0) begin failures++; $display("[TB] FAIL basic_dl_hit_lo: got %b expected 0", dl_in); end
    taps = 32'h0000_00FF;
    tick();
    exp_c = 16'(cyc - 1);
    taps = '0;
    checks++; if (ts_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_valid: got %b expected 0", ts_valid); end
    tick();
    checks++; if (ts_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid: got %b expected 1", ts_valid); end
    checks++; if (ts_data !== {1'b0, exp_c, 6'd8}) begin failures++; $display("[TB] FAIL basic_data: got %h expected %h", ts_data, {1'b0, exp_c, 6'd8}); end
    hit_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (busy !== 1'b1 || dl_in !== 1'b0) begin failures++; $display("[TB] FAIL basic_dead%0d: got busy=%b dl_in=%b expected busy=1 dl_in=0", i, busy, dl_in); end
    end
    tick();
    checks++; if (dl_in !== 1'b1) begin failures++; $display("[TB] FAIL basic_rearmed_dl: got %b expected 1", dl_in); end
    hit_in = 1'b0;
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
    checks++; if (ts_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_ready_clear: got %b expected 0", ts_valid); end
  endtask

  task test_fine_encoding;
    send_hit(32'h0000_0F7F, 1'b0, exp_c);
    checks++; if (ts_data !== {1'b0, exp_c, 6'd7}) begin failures++; $display("[TB] FAIL fine_bubble: got %h expected %h", ts_data, {1'b0, exp_c, 6'd7}); end
    release_and_rearm();
    send_hit(32'hFFFF_FFFF, 1'b0, exp_c);
    checks++; if (ts_data !== {1'b1, exp_c, 6'd32}) begin failures++; $display("[TB] FAIL fine_saturated: got %h expected %h", ts_data, {1'b1, exp_c, 6'd32}); end
    release_and_rearm();
  endtask

  task test_cal_mode;
    arm = 1'b0;
    tick();
    cal_mode = 1'b1;
    arm = 1'b1;
    tick();
    cal_pulse = 1'b1; hit_in = 1'b0; #1;
    checks++; if (dl_in !== 1'b1) begin failures++; $display("[TB] FAIL cal_follow_pulse: got %b expected 1", dl_in); end
    cal_pulse = 1'b0; hit_in = 1'b1; #1;
    checks++; if (dl_in !== 1'b0) begin failures++; $display("[TB] FAIL cal_ignore_hit: got %b expected 0", dl_in); end
    cal_mode = 1'b0;
    tick();
    tick();
    cal_pulse = 1'b1; hit_in = 1'b0; #1;
    checks++; if (dl_in !== 1'b1) begin failures++; $display("[TB] FAIL cal_mode_toggle_ignored: got %b expected 1", dl_in); end
    arm = 1'b0;
    tick();
    hit_in = 1'b1; #1;
    checks++; if (dl_in !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL cal_idle_gate: got dl_in=%b busy=%b expected 0 0", dl_in, busy); end
    cal_pulse = 1'b0; hit_in = 1'b0;
    arm = 1'b1;
    tick();
    hit_in = 1'b1; #1;
    checks++; if (dl_in !== 1'b1) begin failures++; $display("[TB] FAIL rearm_hit_follow: got %b expected 1", dl_in); end
    hit_in = 1'b0; cal_pulse = 1'b1; #1;
    checks++; if (dl_in !== 1'b0) begin failures++; $display("[TB] FAIL rearm_ignore_cal: got %b expected 0", dl_in); end
    cal_pulse = 1'b0;
  endtask

  task test_arm_fall;
    taps = 32'h0000_00FF;
    tick();
    exp_c = 16'(cyc - 1);
    taps = '0;
    arm = 1'b0;
    tick();
    checks++; if (ts_valid !== 1'b1 || ts_data !== {1'b0, exp_c, 6'd8}) begin failures++; $display("[TB] FAIL armfall_ts: got valid=%b data=%h expected 1 %h", ts_valid, ts_data, {1'b0, exp_c, 6'd8}); end
    ts_ready = 1'b1; taps = 32'h0000_00FF;
    tick();
    ts_ready = 1'b0; taps = '0;
    tick();
    taps = 32'h0000_00FF;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL armfall_dead_busy: got %b expected 1", busy); end
    taps = '0;
    tick();
    checks++; if (ts_valid !== 1'b0 || lost_cnt !== 8'd0) begin failures++; $display("[TB] FAIL dead_edges_ignored: got valid=%b lost=%0d expected 0 0", ts_valid, lost_cnt); end
    hit_in = 1'b1; #1;
    checks++; if (busy !== 1'b0 || dl_in !== 1'b0) begin failures++; $display("[TB] FAIL armfall_idle: got busy=%b dl_in=%b expected 0 0", busy, dl_in); end
    hit_in = 1'b0;
    taps = 32'h0000_00FF;
    tick();
    taps = '0;
    tick();
    checks++; if (ts_valid !== 1'b0 || lost_cnt !== 8'd0) begin failures++; $display("[TB] FAIL idle_edge_ignored: got valid=%b lost=%0d expected 0 0", ts_valid, lost_cnt); end
  endtask

  task test_lost;
    arm = 1'b1;
    tick();
    send_hit(32'h0000_0003, 1'b0, exp_c);
    held = {1'b0, exp_c, 6'd2};
    checks++; if (ts_data !== held) begin failures++; $display("[TB] FAIL lost_first_data: got %h expected %h", ts_data, held); end
    repeat (4) tick();
    send_hit(32'h0000_0007, 1'b0, exp_c2);
    checks++; if (lost_cnt !== 8'd1 || ts_data !== held) begin failures++; $display("[TB] FAIL lost_one: got lost=%0d data=%h expected 1 %h", lost_cnt, ts_data, held); end
    repeat (4) tick();
    for (int i = 0; i < 300; i++) begin
      send_hit(32'h0000_0007, 1'b0, exp_c2);
      repeat (4) tick();
    end
    checks++; if (lost_cnt !== 8'd255) begin failures++; $display("[TB] FAIL lost_saturate: got %0d expected 255", lost_cnt); end
    checks++; if (ts_valid !== 1'b1 || ts_data !== held) begin failures++; $display("[TB] FAIL lost_data_stable: got valid=%b data=%h expected 1 %h", ts_valid, ts_data, held); end
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
    checks++; if (ts_valid !== 1'b0) begin failures++; $display("[TB] FAIL lost_ready_clear: got %b expected 0", ts_valid); end
  endtask

  task test_back_to_back;
    send_hit(32'h0000_001F, 1'b0, exp_c);
    checks++; if (ts_data !== {1'b0, exp_c, 6'd5}) begin failures++; $display("[TB] FAIL b2b_first: got %h expected %h", ts_data, {1'b0, exp_c, 6'd5}); end
    repeat (4) tick();
    send_hit(32'h0000_03FF, 1'b1, exp_c2);
    checks++; if (ts_valid !== 1'b1 || ts_data !== {1'b0, exp_c2, 6'd10}) begin failures++; $display("[TB] FAIL b2b_reload: got valid=%b data=%h expected 1 %h", ts_valid, ts_data, {1'b0, exp_c2, 6'd10}); end
    checks++; if (lost_cnt !== 8'd255) begin failures++; $display("[TB] FAIL b2b_no_loss: got %0d expected 255", lost_cnt); end
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
    checks++; if (ts_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_clear: got %b expected 0", ts_valid); end
    repeat (3) tick();
  endtask

  task test_reset_mid;
    send_hit(32'h0000_00FF, 1'b0, exp_c);
    checks++; if (ts_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_pre: got valid=%b busy=%b expected 1 1", ts_valid, busy); end
    rst_n = 1'b0;
    tick();
    checks++; if (ts_valid !== 1'b0 || ts_data !== 23'h0) begin failures++; $display("[TB] FAIL rstmid_ts: got valid=%b data=%h expected 0 0", ts_valid, ts_data); end
    checks++; if (lost_cnt !== 8'd0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_state: got lost=%0d busy=%b expected 0 0", lost_cnt, busy); end
    rst_n = 1'b1;
    tick();
    taps = 32'h0000_00FF;
    tick();
    taps = '0;
    tick();
    checks++; if (ts_data !== {1'b0, 16'd1, 6'd8}) begin failures++; $display("[TB] FAIL rstmid_coarse: got %h expected %h", ts_data, {1'b0, 16'd1, 6'd8}); end
    release_and_rearm();
  endtask

  task test_coarse_wrap;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (65536) tick();
    taps = 32'h0000_00FF;
    tick();
    taps = '0;
    tick();
    checks++; if (ts_valid !== 1'b1 || ts_data !== {1'b0, 16'h0000, 6'd8}) begin failures++; $display("[TB] FAIL coarse_wrap: got valid=%b data=%h expected 1 %h", ts_valid, ts_data, {1'b0, 16'h0000, 6'd8}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fine_encoding();
    test_cal_mode();
    test_arm_fall();
    test_lost();
    test_back_to_back();
    test_reset_mid();
    test_coarse_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
